// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: tag-pipeline entry and select-width helper.
package fwd_pkg;

  localparam int REG_W_MAX    = 8;
  localparam int ZERO_REG_DEF = 31;

  // rd is stored at REG_W_MAX bits, zero-extended from the configured REG_W
  typedef struct packed {
    logic                 v;
    logic [REG_W_MAX-1:0] rd;
    logic                 rw;
    logic                 mr;
  } tag_entry_t;

  function automatic int sel_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one source index against the tag pipeline; youngest producer wins.
// Purely combinational; no flow control.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int STAGES   = 2,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int SEL_W    = 2
) (
  input  tag_entry_t [STAGES-1:0] entries_i,
  input  logic [REG_W-1:0]        src_i,
  input  logic                    used_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    load_hit_o
);

  // Scan oldest to youngest so the last assignment is the smallest index.
  always_comb begin
    sel_o      = '0;
    load_hit_o = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (used_i && entries_i[i].v && entries_i[i].rw &&
          (entries_i[i].rd != REG_W_MAX'(ZERO_REG)) &&
          (entries_i[i].rd == REG_W_MAX'(src_i))) begin
        sel_o      = SEL_W'(i + 1);
        load_hit_o = (i == 0) && entries_i[i].mr;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects (registered, valid one cycle later in EX) and combinational load-use stall.
// freeze holds all state; a stall or flush injects a bubble into the tag pipeline.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC  = 3,
  parameter  int STAGES   = 2,
  parameter  int REG_W    = 5,
  parameter  int ZERO_REG = ZERO_REG_DEF,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = sel_w(STAGES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_W-1:0]         id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     freeze,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     load_stall,
  output logic [CNT_W-1:0]         stall_count
);

  tag_entry_t [STAGES-1:0]    e_q, e_d;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_SRC*SEL_W-1:0]   sel_c;
  logic [NUM_SRC-1:0]         hit_c;
  logic                       bubble;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_match #(
      .STAGES   (STAGES),
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG),
      .SEL_W    (SEL_W)
    ) u_match (
      .entries_i  (e_q),
      .src_i      (id_src[k*REG_W +: REG_W]),
      .used_i     (id_src_used[k]),
      .sel_o      (sel_c[k*SEL_W +: SEL_W]),
      .load_hit_o (hit_c[k])
    );
  end

  assign load_stall = id_valid & ~flush & ~freeze & ~reset & (|hit_c);
  assign bubble     = flush | load_stall | ~id_valid;

  always_comb begin
    e_d       = e_q;
    fwd_sel_d = fwd_sel_q;
    cnt_d     = cnt_q;
    if (!freeze) begin
      for (int i = 1; i < STAGES; i++) begin
        e_d[i] = e_q[i-1];
      end
      e_d[0] = '0;
      if (!bubble) begin
        e_d[0].v  = 1'b1;
        e_d[0].rd = REG_W_MAX'(id_rd);
        e_d[0].rw = id_regwrite;
        e_d[0].mr = id_memread;
      end
      fwd_sel_d = bubble ? '0 : sel_c;
      // Saturate rather than wrap so long runs still read as "many stalls".
      if (load_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q       <= '0;
      fwd_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      e_q       <= e_d;
      fwd_sel_q <= fwd_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fwd_sel     = fwd_sel_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: driver queues expected per-cycle outputs, monitor compares at negedge.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic [14:0] id_src;
  logic [2:0]  id_src_used;
  logic        freeze;
  logic        flush;
  logic [5:0]  fwd_sel;
  logic        load_stall;
  logic [2:0]  stall_count;

  typedef struct packed {
    logic [5:0] sel;
    logic       stall;
    logic [2:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  fwd_hazard_unit #(
    .NUM_SRC  (3),
    .STAGES   (2),
    .REG_W    (5),
    .ZERO_REG (31),
    .CNT_W    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .freeze      (freeze),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .load_stall  (load_stall),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values describe what is visible during the cycle the inputs are applied.
  task automatic step(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                      input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] used, input logic frz, input logic fl, input logic rst,
                      input logic [5:0] esel, input logic estall, input logic [2:0] ecnt,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid    = v;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_src      = {s2, s1, s0};
    id_src_used = used;
    freeze      = frz;
    flush       = fl;
    reset       = rst;
    e.sel   = esel;
    e.stall = estall;
    e.cnt   = ecnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (fwd_sel !== e.sel) begin
        bad++;
        $display("FAIL %s.fwd_sel got=%b want=%b", nm, fwd_sel, e.sel);
      end
      total++;
      if (load_stall !== e.stall) begin
        bad++;
        $display("FAIL %s.load_stall got=%b want=%b", nm, load_stall, e.stall);
      end
      total++;
      if (stall_count !== e.cnt) begin
        bad++;
        $display("FAIL %s.stall_count got=%0d want=%0d", nm, stall_count, e.cnt);
      end
    end
  end

  initial begin
    logic [2:0] c;
    logic [2:0] cn;
    reset = 1'b1; id_valid = 1'b0; id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;
    id_src = '0; id_src_used = '0; freeze = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    //    v  rd  rw mr  s0  s1  s2  used   frz fl rst  sel        stl cnt
    step(1, 1,  1, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 0, "reset_state");
    step(1, 5,  0, 0,  1,  0,  0,  3'b001, 0, 0, 0, 6'b000000, 0, 0, "add_x1_ex");
    step(1, 6,  0, 0,  0,  1,  0,  3'b010, 0, 0, 0, 6'b000001, 0, 0, "fwd_ex_rn");
    step(1, 2,  1, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b001000, 0, 0, "fwd_wb_rm");
    step(1, 2,  1, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 0, "x2_second");
    step(1, 7,  0, 0,  2,  0,  2,  3'b101, 0, 0, 0, 6'b000000, 0, 0, "read_x2");
    step(1, 3,  1, 1,  0,  0,  0,  3'b000, 0, 0, 0, 6'b010001, 0, 0, "fwd_youngest");
    step(1, 8,  1, 0,  0,  3,  0,  3'b010, 0, 0, 0, 6'b000000, 1, 0, "load_use");
    step(1, 8,  1, 0,  0,  3,  0,  3'b010, 0, 0, 0, 6'b000000, 0, 1, "stall_bubble");
    step(0, 0,  0, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b001000, 0, 1, "fwd_after_load");
    step(1, 31, 1, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 1, "add_xzr");
    step(1, 9,  0, 0, 31, 31, 31,  3'b111, 0, 0, 0, 6'b000000, 0, 1, "read_xzr");
    step(0, 0,  0, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 1, "xzr_sel");
    step(1, 4,  1, 1,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 1, "ldur_x4");
    step(1, 10, 1, 0,  4,  0,  0,  3'b001, 0, 1, 0, 6'b000000, 0, 1, "flush_no_stall");
    step(0, 0,  0, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 1, "flush_bubble");
    step(1, 5,  1, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 1, "add_x5");
    step(1, 11, 0, 0,  5,  0,  0,  3'b001, 0, 0, 0, 6'b000000, 0, 1, "read_x5");
    step(1, 12, 1, 0,  0,  5,  0,  3'b010, 1, 0, 0, 6'b000001, 0, 1, "freeze_1");
    step(1, 12, 1, 0,  0,  5,  0,  3'b010, 1, 0, 0, 6'b000001, 0, 1, "freeze_2");
    step(1, 12, 1, 0,  0,  5,  0,  3'b010, 1, 0, 0, 6'b000001, 0, 1, "freeze_3");
    step(1, 12, 1, 0,  0,  5,  0,  3'b010, 0, 0, 0, 6'b000001, 0, 1, "unfreeze");
    step(0, 0,  0, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b001000, 0, 1, "post_freeze");
    step(1, 6,  1, 1,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 1, "ldur_x6");
    step(1, 13, 1, 0,  0,  0,  6,  3'b100, 1, 0, 0, 6'b000000, 0, 1, "frozen_load_use");
    step(1, 13, 1, 0,  0,  0,  6,  3'b100, 0, 0, 0, 6'b000000, 1, 1, "load_use_st");
    step(1, 13, 1, 0,  0,  0,  6,  3'b100, 0, 0, 0, 6'b000000, 0, 2, "reeval_st");
    step(1, 7,  1, 1,  0,  0,  0,  3'b000, 0, 0, 0, 6'b100000, 0, 2, "fwd_wb_st");
    step(1, 14, 1, 0,  7,  0,  0,  3'b001, 0, 0, 1, 6'b000000, 0, 2, "reset_mid_stall");
    step(1, 14, 1, 0,  7,  0,  0,  3'b001, 0, 0, 0, 6'b000000, 0, 0, "reset_clear");
    step(0, 0,  0, 0,  0,  0,  0,  3'b000, 0, 0, 0, 6'b000000, 0, 0, "idle");

    // Repeated load-use pairs drive the 3-bit counter into saturation.
    c = 3'd0;
    for (int n = 0; n < 9; n++) begin
      cn = (c == 3'd7) ? 3'd7 : c + 3'd1;
      step(1, 3,  1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 6'b000000, 0, c,  "sat_load");
      step(1, 15, 0, 0, 3, 0, 0, 3'b001, 0, 0, 0, 6'b000000, 1, c,  "sat_stall");
      step(0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 6'b000000, 0, cn, "sat_idle");
      c = cn;
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
